// File: rtl/routermerge_arbiter.sv
// Round-robin select-stream scheduler for the 5-input router merge.
// Optional packet lock (tail-driven grant hold) enabled by ROUTERMERGE_PKT_LOCK_EN.
module routermerge_arbiter #(
  parameter int unsigned N_IN        = 5,
  parameter int unsigned CODE_W      = 3,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IN-1:0]   req,
`ifdef ROUTERMERGE_PKT_LOCK_EN
  input  logic [N_IN-1:0]   tail,
`endif
  output logic              ctrl_valid,
  input  logic              ctrl_ready,
  output logic [CODE_W-1:0] ctrl_code,
  output logic [N_IN-1:0]   grant_onehot,
  input  logic              xfer_done,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int unsigned     WD_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam bit              WD_EN   = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_e;

  state_e              state_q;
  logic                ctrl_valid_q;
  logic [CODE_W-1:0]   ctrl_code_q;
  logic [N_IN-1:0]     grant_q;
  logic                busy_q;
  logic                timeout_err_q;
  logic [CODE_W-1:0]   rr_ptr_q;
  logic [WD_W-1:0]     wd_q;

  logic [CODE_W-1:0]   win_idx_c;
  logic                win_found_c;
  logic                done_c;
  logic                relock_c;
  logic                wd_hit_c;
  int unsigned         dist_c;
  int unsigned         best_c;

`ifdef ROUTERMERGE_PKT_LOCK_EN
  logic                tail_q;
  logic                lock_wait_q;
`endif

  // Winner is the requester with the smallest upward distance past rr_ptr_q.
  always_comb begin
    win_idx_c = '0;
    best_c    = N_IN;
    dist_c    = 0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      dist_c = (i + 2 * N_IN - 1 - 32'(rr_ptr_q)) % N_IN;
      if (req[i] && (dist_c < best_c)) begin
        best_c    = dist_c;
        win_idx_c = CODE_W'(i);
      end
    end
  end

  assign win_found_c = |req;

`ifdef ROUTERMERGE_PKT_LOCK_EN
  assign done_c   = xfer_done && !lock_wait_q;
  assign relock_c = lock_wait_q && req[ctrl_code_q];
`else
  assign done_c   = xfer_done;
  assign relock_c = 1'b0;
`endif

  // A completion or relock in the same cycle beats the watchdog.
  assign wd_hit_c = WD_EN && (state_q == S_BUSY) && !done_c && !relock_c && (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ctrl_valid_q  <= 1'b0;
      ctrl_code_q   <= '0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= CODE_W'(N_IN - 1);
      wd_q          <= '0;
`ifdef ROUTERMERGE_PKT_LOCK_EN
      tail_q        <= 1'b0;
      lock_wait_q   <= 1'b0;
`endif
    end else begin
      timeout_err_q <= wd_hit_c ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
      unique case (state_q)
        S_IDLE: begin
          if (win_found_c) begin
            state_q      <= S_ISSUE;
            busy_q       <= 1'b1;
            ctrl_valid_q <= 1'b1;
            ctrl_code_q  <= win_idx_c;
            grant_q      <= N_IN'(1) << win_idx_c;
`ifdef ROUTERMERGE_PKT_LOCK_EN
            tail_q       <= tail[win_idx_c];
`endif
          end
        end
        S_ISSUE: begin
          if (ctrl_ready) begin
            state_q      <= S_BUSY;
            ctrl_valid_q <= 1'b0;
            rr_ptr_q     <= ctrl_code_q;
            wd_q         <= '0;
          end
        end
        S_BUSY: begin
          if (wd_hit_c) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            grant_q     <= '0;
`ifdef ROUTERMERGE_PKT_LOCK_EN
            lock_wait_q <= 1'b0;
`endif
          end
`ifdef ROUTERMERGE_PKT_LOCK_EN
          // Mid-packet: the same input is re-issued as soon as it has a flit.
          else if (relock_c || (done_c && !tail_q && req[ctrl_code_q])) begin
            state_q      <= S_ISSUE;
            ctrl_valid_q <= 1'b1;
            tail_q       <= tail[ctrl_code_q];
            lock_wait_q  <= 1'b0;
          end else if (done_c && !tail_q) begin
            lock_wait_q <= 1'b1;
            wd_q        <= wd_q + WD_W'(1);
          end
`endif
          else if (done_c) begin
            if (win_found_c) begin
              state_q      <= S_ISSUE;
              ctrl_valid_q <= 1'b1;
              ctrl_code_q  <= win_idx_c;
              grant_q      <= N_IN'(1) << win_idx_c;
`ifdef ROUTERMERGE_PKT_LOCK_EN
              tail_q       <= tail[win_idx_c];
`endif
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              grant_q <= '0;
            end
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ctrl_valid   = ctrl_valid_q;
  assign ctrl_code    = ctrl_code_q;
  assign grant_onehot = grant_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_routermerge_arbiter.sv
// Scoreboard bench for routermerge_arbiter: a reference model predicts grants and
// per-cycle status; a monitor compares them whenever the DUT presents them.
module tb_routermerge_arbiter;

  localparam int unsigned N_IN   = 5;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned TO     = 8;
  localparam int unsigned IW     = $clog2(N_IN);
  localparam int          NCYC   = 1500;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_IN-1:0]   req;
  logic [N_IN-1:0]   tail;
  logic              ctrl_valid;
  logic              ctrl_ready;
  logic [CODE_W-1:0] ctrl_code;
  logic [N_IN-1:0]   grant_onehot;
  logic              xfer_done;
  logic              busy;
  logic              timeout_err;
  logic              err_clr;

  always #5 clk = ~clk;

  routermerge_arbiter #(.N_IN(N_IN), .CODE_W(CODE_W), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
`ifdef ROUTERMERGE_PKT_LOCK_EN
    .tail         (tail),
`endif
    .ctrl_valid   (ctrl_valid),
    .ctrl_ready   (ctrl_ready),
    .ctrl_code    (ctrl_code),
    .grant_onehot (grant_onehot),
    .xfer_done    (xfer_done),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  typedef struct packed {
    logic            v;
    logic            b;
    logic            e;
    logic [N_IN-1:0] oh;
  } obs_t;

  int unsigned exp_q[$];
  obs_t        cyc_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;

  // Reference: 0 = nothing owed, 1 = grant offered, 2 = flit in flight.
  int          m_phase;
  int unsigned m_last;
  int unsigned m_cur;
  int unsigned m_age;
  bit          m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned pick(input logic [N_IN-1:0] r, input int unsigned last);
    for (int unsigned k = 1; k <= N_IN; k++) begin
      int unsigned j;
      j = (last + k) % N_IN;
      if (r[IW'(j)]) return j;
    end
    return 0;
  endfunction

  task automatic model_step();
    obs_t o;
    bit   set_err;
    set_err = 1'b0;
    case (m_phase)
      0: if (req != '0) begin
           m_cur = pick(req, m_last);
           exp_q.push_back(m_cur);
           m_phase = 1;
         end
      1: if (ctrl_ready) begin
           m_last  = m_cur;
           m_age   = 0;
           m_phase = 2;
         end
      default: begin
        if (xfer_done) begin
          if (req != '0) begin
            m_cur = pick(req, m_last);
            exp_q.push_back(m_cur);
            m_phase = 1;
          end else begin
            m_phase = 0;
          end
        end else if (m_age == TO - 1) begin
          set_err = 1'b1;
          m_phase = 0;
        end else begin
          m_age++;
        end
      end
    endcase
    if (set_err) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    o.v  = (m_phase == 1);
    o.b  = (m_phase != 0);
    o.e  = m_err;
    o.oh = (m_phase != 0) ? (N_IN'(1) << m_cur) : '0;
    cyc_q.push_back(o);
  endtask

  task automatic drive(input int c);
    if (c < 6) begin
      req = 5'b00100; ctrl_ready = 1'b1; xfer_done = (c == 3); err_clr = 1'b0;
    end else if (c < 60) begin
      req = 5'b11111; ctrl_ready = 1'b1; xfer_done = ($urandom_range(0, 1) == 1); err_clr = 1'b0;
    end else if (c < NCYC - 20) begin
      req        = N_IN'($urandom) & N_IN'($urandom);
      ctrl_ready = ($urandom_range(0, 9) < 6);
      xfer_done  = ($urandom_range(0, 9) < 3);
      err_clr    = ($urandom_range(0, 9) == 0);
    end else begin
      req = '0; ctrl_ready = 1'b1; xfer_done = 1'b1; err_clr = 1'b1;
    end
  endtask

  // Stimulus and reference model
  initial begin
    reset = 1'b1; req = '0; tail = '1; ctrl_ready = 1'b0; xfer_done = 1'b0; err_clr = 1'b0;
    m_phase = 0; m_last = N_IN - 1; m_cur = 0; m_age = 0; m_err = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      model_step();
      #2;
      drive(c);
    end
    repeat (2) @(negedge clk);
    check("grants_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Monitor
  initial begin
    obs_t        o;
    obs_t        e;
    int unsigned g;
    forever begin
      @(negedge clk);
      o = '{v: ctrl_valid, b: busy, e: timeout_err, oh: grant_onehot};
      if (reset) begin
        check("reset_state", 32'({o, ctrl_code}), 32'd0);
      end else begin
        if (cyc_q.size() != 0) begin
          e = cyc_q.pop_front();
          check("cycle_status", 32'(o), 32'(e));
        end
        if (ctrl_valid && ctrl_ready) begin
          if (exp_q.size() == 0) begin
            check("grant_unexpected", 32'(ctrl_code), 32'hFFFF_FFFF);
          end else begin
            g = exp_q.pop_front();
            check("grant_code", 32'(ctrl_code), 32'(g));
          end
        end
      end
    end
  end

endmodule

// File: doc/routermerge_arbiter.md
Name: routermerge_arbiter

Overview:
- Synchronous round-robin scheduler that generates the 3-bit select stream for the 5-input router merge.
- Watches per-input "flit pending" requests and picks one input fairly.
- Issues the input's code (000..100) on a valid/ready control channel, then waits for the merge to report that the flit has been forwarded.
- Sits between the five input-port buffers and the merge's control input; one instance per router output.

Parameters:
- N_IN, 5, number of merge inputs; codes 0..N_IN-1; legal range 2..8.
- CODE_W, 3, width of ctrl_code; must satisfy 2^CODE_W >= N_IN.
- TIMEOUT_CYC, 1024, maximum cycles in BUSY before the watchdog fires; 0 disables the watchdog.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_IN  bit i = input i has a flit pending.
- ctrl_valid  output  1  ctrl_code is valid.
- ctrl_ready  input  1  merge accepts ctrl_code this cycle.
- ctrl_code  output  CODE_W  binary index of the granted input.
- grant_onehot  output  N_IN  one-hot copy of the current grant; held through ISSUE and BUSY.
- xfer_done  input  1  single-cycle pulse: merge completed the output send.
- busy  output  1  high in ISSUE or BUSY.
- timeout_err  output  1  sticky watchdog error.
- err_clr  input  1  clears timeout_err.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, ctrl_valid=0, ctrl_code=0, grant_onehot=0, busy=0, timeout_err=0, rr_ptr=N_IN-1 (so input 0 has first priority), wd_cnt=0.
- Arbitration (combinational):
  - Search req starting at (rr_ptr+1) mod N_IN, wrapping upward.
  - The first set bit wins.
- IDLE:
  - If req!=0, register the winner into ctrl_code and grant_onehot, set ctrl_valid=1, go to ISSUE.
  - Latency from req to ctrl_valid is 1 cycle.
  - If req==0, stay in IDLE.
- ISSUE:
  - ctrl_code, grant_onehot and ctrl_valid are held stable until ctrl_valid&ctrl_ready.
  - On handshake: rr_ptr<=granted index, ctrl_valid<=0, wd_cnt<=0, go to BUSY.
  - Changes on req are ignored; the grant is committed.
- BUSY:
  - wd_cnt increments each cycle.
  - On xfer_done: if req!=0, arbitrate from the updated rr_ptr in the same cycle, load the new grant, set ctrl_valid=1, go to ISSUE (back-to-back, no idle bubble).
  - On xfer_done with req==0: go to IDLE and clear grant_onehot.
- Watchdog:
  - If TIMEOUT_CYC!=0 and wd_cnt reaches TIMEOUT_CYC-1 in BUSY without xfer_done, set timeout_err=1, clear grant_onehot, go to IDLE.
  - xfer_done in the same cycle takes priority; no error is raised.
- xfer_done in IDLE or ISSUE is ignored.
- err_clr clears timeout_err on the next edge. If err_clr and a new timeout occur in the same cycle, the set wins.
- busy = (state==ISSUE || state==BUSY).
- Request bits at or above N_IN do not exist; codes >= N_IN are never issued.
- Reset mid-operation aborts any grant immediately; ctrl_valid drops asynchronously.

Optional Feature:
- Macro ROUTERMERGE_PKT_LOCK_EN.
- When defined:
  - Adds input port tail (N_IN bits): tail[i] marks that the pending flit on input i is the last flit of its packet.
  - The tail bit of the granted input is captured at grant.
  - On xfer_done with captured tail=0, the next grant is forced to the same input (wait in BUSY->ISSUE for req[i]); rr_ptr does not advance until a tail flit completes.
  - The watchdog also covers the wait for req[i] in the locked state.
- When undefined:
  - No tail port; every flit is arbitrated independently.

Test Plan:
- After reset, req=5'b00100, ctrl_ready=1 -> ctrl_valid=1, ctrl_code=3'b010 one cycle later; after the handshake busy=1; xfer_done -> IDLE, grant_onehot=0.
- req=5'b11111 held, ctrl_ready=1, xfer_done pulsed 2 cycles after each grant -> codes 0,1,2,3,4,0 in order, no IDLE bubble between grants.
- req=5'b10001, rr_ptr=0 -> code 4 granted, then code 0 (wrap-around).
- ctrl_ready=0 for 5 cycles while req changes -> ctrl_code stays constant and ctrl_valid stays 1; handshake occurs on the first ready.
- TIMEOUT_CYC=8, no xfer_done after the grant -> timeout_err=1 on the 8th BUSY cycle, state IDLE; err_clr -> timeout_err=0 next cycle.
- ROUTERMERGE_PKT_LOCK_EN with req=5'b00011, tail[0]=0,0,1 over three flits -> codes 0,0,0, then 1.
